// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the aluop encodings for loads and stores, the pipeline control
// encodings, the FSM state type and the bus transfer-size type.
package mem_lsu_pkg;

  localparam int          LSU_ADDR_W = 32;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b1;
  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } lsu_size_e;

endpackage

// File: rtl/mem_lsu_if.sv
// SRAM-like data bus between the load/store unit and memory.
// master: the LSU (drives req/wr/size/addr/wdata, receives handshakes and rdata).
// slave:  the memory side (the reverse directions).
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [LSU_ADDR_W-1:0] data_addr;
  logic [31:0]           data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [31:0]           data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Combinational decode of a load/store: transfer size, store lane replication,
// load lane select with sign/zero extension, and misalignment detection.
// Ports: aluop/addr_lo/reg2/rdata in; is_mem, is_load, size, misalign, wdata, load_data out.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int ALUOP_W = 8
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         addr_lo,
  input  logic [31:0]        reg2,
  input  logic [31:0]        rdata,
  output logic               is_mem,
  output logic               is_load,
  output logic [1:0]         size,
  output logic               misalign,
  output logic [31:0]        wdata,
  output logic [31:0]        load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
    lane_b    = rdata[{addr_lo, 3'b000} +: 8];
    lane_h    = rdata[{addr_lo[1], 4'b0000} +: 16];
    is_mem    = 1'b1;
    is_load   = 1'b1;
    size      = SIZE_WORD;
    wdata     = reg2;
    load_data = rdata;
    case (aluop)
      EXE_LB_OP:  begin size = SIZE_BYTE; load_data = {{24{lane_b[7]}}, lane_b}; end
      EXE_LBU_OP: begin size = SIZE_BYTE; load_data = {24'h0, lane_b}; end
      EXE_LH_OP:  begin size = SIZE_HALF; load_data = {{16{lane_h[15]}}, lane_h}; end
      EXE_LHU_OP: begin size = SIZE_HALF; load_data = {16'h0, lane_h}; end
      EXE_LW_OP:  begin size = SIZE_WORD; end
      EXE_SB_OP:  begin is_load = 1'b0; size = SIZE_BYTE; wdata = {4{reg2[7:0]}}; end
      EXE_SH_OP:  begin is_load = 1'b0; size = SIZE_HALF; wdata = {2{reg2[15:0]}}; end
      EXE_SW_OP:  begin is_load = 1'b0; end
      default:    begin is_mem = 1'b0; is_load = 1'b0; end
    endcase
    misalign = is_mem & (((size == SIZE_HALF) & addr_lo[0]) |
                         ((size == SIZE_WORD) & (|addr_lo)));
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one bus access per mem instruction, holds the
// pipeline until it completes, and returns the extended load data.
// Ports: clk/resetn, EX/MEM fields, stall/flush, data bus (mem_lsu_if.master),
// mem_load_data, stallreq_mem, adel/ades.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ALUOP_W = 8,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [ALUOP_W-1:0] mem_aluop,
  input  logic [ADDR_W-1:0]  mem_mem_addr,
  input  logic [31:0]        mem_reg2,
  input  logic [5:0]         stall,
  input  logic               flush,
  mem_lsu_if.master          bus,
  output logic [31:0]        mem_load_data,
  output logic               stallreq_mem,
  output logic               adel,
  output logic               ades
);

  lsu_state_e        state_q, state_d;
  logic              cancel_q, cancel_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_q, load_d;

  logic        is_mem, is_load, misalign, launch, complete;
  logic [1:0]  size;
  logic [31:0] wdata, load_data;
  logic        unused_stall_bits;

  assign unused_stall_bits = ^{stall[5:4], stall[2:0]};

  mem_lsu_align #(.ALUOP_W(ALUOP_W)) u_align (
    .aluop     (mem_aluop),
    .addr_lo   (mem_mem_addr[1:0]),
    .reg2      (mem_reg2),
    .rdata     (bus.data_rdata),
    .is_mem    (is_mem),
    .is_load   (is_load),
    .size      (size),
    .misalign  (misalign),
    .wdata     (wdata),
    .load_data (load_data)
  );

  assign launch = is_mem & ~misalign & ~flush;

  always_comb begin
    state_d      = state_q;
    cancel_d     = cancel_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_d       = load_q;
    stallreq_mem = 1'b0;
    complete     = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (launch) begin
          state_d      = LSU_REQ;
          wr_d         = ~is_load;
          size_d       = size;
          addr_d       = mem_mem_addr;
          wdata_d      = wdata;
          stallreq_mem = 1'b1;
        end
      end
      LSU_REQ: begin
        // A request once raised is never withdrawn; a flush only marks it cancelled.
        stallreq_mem = ~cancel_q;
        if (flush) cancel_d = 1'b1;
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) complete = 1'b1;
          else                  state_d  = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        stallreq_mem = ~cancel_q;
        if (flush) cancel_d = 1'b1;
        if (bus.data_data_ok) complete = 1'b1;
      end
      LSU_DONE: begin
        // Wait for the pipeline to move on so the same instruction is not reissued.
        if ((stall[3] == NO_STOP) || flush) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase

    if (complete) begin
      if (cancel_q || flush) begin
        // Cancelled response: swallow it and leave the result untouched.
        state_d  = LSU_IDLE;
        cancel_d = 1'b0;
      end else begin
        state_d = LSU_DONE;
        if (!wr_q) load_d = load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn == RST_ENABLE) begin
      state_q  <= LSU_IDLE;
      cancel_q <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= ZERO_WORD;
      load_q   <= ZERO_WORD;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      load_q   <= load_d;
    end
  end

  assign bus.data_req   = (state_q == LSU_REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign mem_load_data  = load_q;
  assign adel           = misalign & is_load;
  assign ades           = misalign & ~is_load;

endmodule
